// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and the register index type for the regfile write side
package regfile_pkg;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int XZR_IDX = 31;
  typedef logic [AW-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_wr_if.sv
// regfile_wr_if: write-back, reservation and contents bus between the core and the regfile write side
interface regfile_wr_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64
);
  logic                  WE;
  reg_idx_t              DA;
  logic [WIDTH-1:0]      D;
  logic                  RV;
  reg_idx_t              RA;
  logic [NREG*WIDTH-1:0] Q;
  logic [NREG-1:0]       BUSY;
  logic [15:0]           WCNT;
  modport master (output WE, DA, D, RV, RA, input Q, BUSY, WCNT);
  modport slave (input WE, DA, D, RV, RA, output Q, BUSY, WCNT);
endinterface

// File: rtl/regfile_dec5to32.sv
// regfile_dec5to32: 5-to-32 one-hot decoder with enable
module regfile_dec5to32
  import regfile_pkg::*;
(
  input  logic            en,
  input  reg_idx_t        idx,
  output logic [NREG-1:0] y
);
  always_comb y = en ? NREG'(1) << idx : '0;
endmodule

// File: rtl/regfile_wr.sv
// regfile_wr: 32 x WIDTH register array with busy scoreboard and saturating write counter.
// Define REGFILE_XZR_EN to make register 31 a hardwired zero register.
module regfile_wr
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64
)(
  input logic         clock,
  input logic         reset,
  regfile_wr_if.slave bus
);
  logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [15:0]                wcnt_q, wcnt_d;
  logic [NREG-1:0]            we_oh, rv_oh;
  regfile_dec5to32 u_dec_wr (.en(bus.WE), .idx(bus.DA), .y(we_oh));
  regfile_dec5to32 u_dec_rv (.en(bus.RV), .idx(bus.RA), .y(rv_oh));
  // reservation is OR-ed in after the clear so a same-index new producer wins
  always_comb begin
    regs_d = regs_q;
    busy_d = (busy_q & ~we_oh) | rv_oh;
    wcnt_d = (bus.WE && wcnt_q != 16'hFFFF) ? wcnt_q + 16'd1 : wcnt_q;
    for (int i = 0; i < NREG; i++) regs_d[i] = we_oh[i] ? bus.D : regs_q[i];
`ifdef REGFILE_XZR_EN
    regs_d[XZR_IDX] = '0;
    busy_d[XZR_IDX] = 1'b0;
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
      wcnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      wcnt_q <= wcnt_d;
    end
  end
  assign bus.Q = regs_q;
  assign bus.BUSY = busy_q;
  assign bus.WCNT = wcnt_q;
endmodule
